y_operand_buffer: RTL and testbench

Bus-side operand receiver feeding the ALU's second input; the inverse path of the Z result register, which drives ALU results onto the shared bus. Captures 16-bit words from the internal bus on `Y_in`, holds up to two in a primary/replica pair, presents the oldest to the ALU with a valid flag, and releases it when the ALU signals consumption. Lets the control sequencer load the next operand while the ALU still uses the current one.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/y_operand_buffer.sv | 109 ++++++++++
 tb/tb_y_operand_buffer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU datapath types: bus word width and Y operand buffer states.
package cpu_pkg;

    localparam int unsigned WORD_W = 16;

    typedef enum logic [1:0] {
        Y_EMPTY = 2'd0,
        Y_ONE   = 2'd1,
        Y_TWO   = 2'd2
    } y_state_t;

    // Occupancy of the Y buffer for a given state.
    function automatic logic [1:0] y_count(input y_state_t s);
        unique case (s)
            Y_ONE:   y_count = 2'd1;
            Y_TWO:   y_count = 2'd2;
            default: y_count = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/y_operand_buffer.sv
// Two-deep operand buffer between the internal bus and the ALU's second input.
// Y1 is presented to the ALU, Y2 waits behind it. A push to a full buffer is
// dropped and latches the sticky overflow flag.
// Optional feature macro: Y_OPERAND_BYPASS_EN. When defined, a push into an
// empty buffer is forwarded to the ALU in the same cycle, and a simultaneous
// take consumes it without the word ever being stored.
module y_operand_buffer
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] from_bus,
    input  logic             Y_in,
    input  logic             ALU_take,
    output logic [WIDTH-1:0] to_ALU,
    output logic             operand_valid,
    output logic             full,
    output logic [1:0]       count,
    output logic             overflow
);

    y_state_t         state_q, state_d;
    logic [WIDTH-1:0] y1_q, y1_d;
    logic [WIDTH-1:0] y2_q, y2_d;
    logic             overflow_q, overflow_d;

    // State and slot registers; reset clears everything asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= Y_EMPTY;
            y1_q       <= '0;
            y2_q       <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            y1_q       <= y1_d;
            y2_q       <= y2_d;
            overflow_q <= overflow_d;
        end
    end

    // Next-state: push/pop decode per occupancy.
    always_comb begin
        state_d    = state_q;
        y1_d       = y1_q;
        y2_d       = y2_q;
        overflow_d = overflow_q;

        unique case (state_q)
            Y_EMPTY: begin
`ifdef Y_OPERAND_BYPASS_EN
                // With a same-cycle take the word goes straight through.
                if (Y_in && !ALU_take) begin
                    state_d = Y_ONE;
                    y1_d    = from_bus;
                end
`else
                // A take while empty is ignored; the push still lands.
                if (Y_in) begin
                    state_d = Y_ONE;
                    y1_d    = from_bus;
                end
`endif
            end
            Y_ONE: begin
                if (Y_in && ALU_take) begin
                    y1_d = from_bus;
                end else if (Y_in) begin
                    state_d = Y_TWO;
                    y2_d    = from_bus;
                end else if (ALU_take) begin
                    state_d = Y_EMPTY;
                end
            end
            Y_TWO: begin
                if (Y_in && ALU_take) begin
                    y1_d = y2_q;
                    y2_d = from_bus;
                end else if (Y_in) begin
                    overflow_d = 1'b1;
                end else if (ALU_take) begin
                    state_d = Y_ONE;
                    y1_d    = y2_q;
                end
            end
            default: begin
                state_d = Y_EMPTY;
            end
        endcase
    end

    // Outputs decoded from registered state (plus the optional bypass path).
    always_comb begin
        operand_valid = (state_q != Y_EMPTY);
        to_ALU        = (state_q != Y_EMPTY) ? y1_q : '0;
`ifdef Y_OPERAND_BYPASS_EN
        if (state_q == Y_EMPTY && Y_in) begin
            operand_valid = 1'b1;
            to_ALU        = from_bus;
        end
`endif
        full     = (state_q == Y_TWO);
        count    = y_count(state_q);
        overflow = overflow_q;
    end

endmodule

// File: tb/tb_y_operand_buffer.sv
// Self-checking bench for y_operand_buffer: a table of push/pop/reset steps with
// constant expectations, queued when driven and compared after the clock edge,
// plus a hand-written check of the empty push-with-take cycle.
module tb_y_operand_buffer;

    localparam int unsigned W = 16;

    logic         clk;
    logic         reset;
    logic [W-1:0] from_bus;
    logic         Y_in;
    logic         ALU_take;
    logic [W-1:0] to_ALU;
    logic         operand_valid;
    logic         full;
    logic [1:0]   count;
    logic         overflow;

    y_operand_buffer #(
        .WIDTH(W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .from_bus     (from_bus),
        .Y_in         (Y_in),
        .ALU_take     (ALU_take),
        .to_ALU       (to_ALU),
        .operand_valid(operand_valid),
        .full         (full),
        .count        (count),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit           rst;
        bit           push;
        bit           pop;
        logic [W-1:0] data;
        logic [W-1:0] e_alu;
        bit           e_valid;
        logic [1:0]   e_count;
        bit           e_full;
        bit           e_ovf;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_applied = 0;
    int   n_miss    = 0;
    int   vec_idx   = 0;

    function automatic vec_t mk(bit rst, bit push, bit pop, logic [W-1:0] data,
                                logic [W-1:0] e_alu, bit e_valid, logic [1:0] e_count,
                                bit e_full, bit e_ovf);
        vec_t v;
        v.rst = rst; v.push = push; v.pop = pop; v.data = data;
        v.e_alu = e_alu; v.e_valid = e_valid; v.e_count = e_count;
        v.e_full = e_full; v.e_ovf = e_ovf;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic compare_front();
        vec_t e;
        if (exp_q.size() == 0) begin
            n_applied++;
            n_miss++;
            $display("FAIL vec%0d scoreboard: got empty queue, want an entry", vec_idx);
            return;
        end
        e = exp_q.pop_front();
        check($sformatf("vec%0d to_ALU", vec_idx), 32'(to_ALU), 32'(e.e_alu));
        check($sformatf("vec%0d operand_valid", vec_idx), 32'(operand_valid), 32'(e.e_valid));
        check($sformatf("vec%0d count", vec_idx), 32'(count), 32'(e.e_count));
        check($sformatf("vec%0d full", vec_idx), 32'(full), 32'(e.e_full));
        check($sformatf("vec%0d overflow", vec_idx), 32'(overflow), 32'(e.e_ovf));
    endtask

    task automatic apply(input vec_t v);
        if (v.rst) begin
            // Drop reset between edges and look before any clock arrives.
            @(posedge clk);
            #3;
            exp_q.push_back(v);
            reset = 1'b0;
            #1;
            compare_front();
            @(negedge clk);
            reset = 1'b1;
        end else begin
            @(negedge clk);
            Y_in     = v.push;
            ALU_take = v.pop;
            from_bus = v.data;
            exp_q.push_back(v);
            @(posedge clk);
            #1;
            Y_in     = 1'b0;
            ALU_take = 1'b0;
            from_bus = '0;
            #1;
            compare_front();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b0;
        from_bus = '0;
        Y_in     = 1'b0;
        ALU_take = 1'b0;
        #12;
        reset = 1'b1;

        //              rst push pop data      alu      vld cnt full ovf
        vecs.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 0, 2'd0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 16'h1234, 16'h1234, 1, 2'd1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 16'h0000, 16'h0000, 0, 2'd0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 16'hAAAA, 16'hAAAA, 1, 2'd1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 16'h5555, 16'hAAAA, 1, 2'd2, 1, 0));
        vecs.push_back(mk(0, 0, 1, 16'h0000, 16'h5555, 1, 2'd1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 16'h0000, 16'h0000, 0, 2'd0, 0, 0));
        // Pop while empty is ignored.
        vecs.push_back(mk(0, 0, 1, 16'h0000, 16'h0000, 0, 2'd0, 0, 0));
        // Overflow: third push dropped, contents kept, flag sticky.
        vecs.push_back(mk(0, 1, 0, 16'h0001, 16'h0001, 1, 2'd1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0002, 16'h0001, 1, 2'd2, 1, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0003, 16'h0001, 1, 2'd2, 1, 1));
        vecs.push_back(mk(0, 0, 1, 16'h0000, 16'h0002, 1, 2'd1, 0, 1));
        vecs.push_back(mk(0, 0, 1, 16'h0000, 16'h0000, 0, 2'd0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 2'd0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 0, 2'd0, 0, 0));
        // Push with pop while full: shifts, no overflow.
        vecs.push_back(mk(0, 1, 0, 16'h0001, 16'h0001, 1, 2'd1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0002, 16'h0001, 1, 2'd2, 1, 0));
        vecs.push_back(mk(0, 1, 1, 16'h0009, 16'h0002, 1, 2'd2, 1, 0));
        vecs.push_back(mk(0, 0, 1, 16'h0000, 16'h0009, 1, 2'd1, 0, 0));
        // Push with pop while holding one: replaces the presented word.
        vecs.push_back(mk(0, 1, 1, 16'h4321, 16'h4321, 1, 2'd1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 16'h0000, 16'h0000, 0, 2'd0, 0, 0));
`ifdef Y_OPERAND_BYPASS_EN
        vecs.push_back(mk(0, 1, 1, 16'hBEEF, 16'h0000, 0, 2'd0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 16'h7777, 16'h7777, 1, 2'd1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 16'h8888, 16'h7777, 1, 2'd2, 1, 0));
`else
        vecs.push_back(mk(0, 1, 1, 16'hBEEF, 16'hBEEF, 1, 2'd1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 16'h7777, 16'hBEEF, 1, 2'd2, 1, 0));
`endif
        // Async reset with two operands held.
        vecs.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 0, 2'd0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 2'd0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            vec_idx = i;
            apply(vecs[i]);
        end

        // Same-cycle view of a push with take into an empty buffer.
        @(negedge clk);
        Y_in     = 1'b1;
        ALU_take = 1'b1;
        from_bus = 16'hBEEF;
        #1;
`ifdef Y_OPERAND_BYPASS_EN
        check("bypass same-cycle to_ALU", 32'(to_ALU), 32'h0000_BEEF);
        check("bypass same-cycle valid", 32'(operand_valid), 32'd1);
`else
        check("empty same-cycle to_ALU", 32'(to_ALU), 32'h0000_0000);
        check("empty same-cycle valid", 32'(operand_valid), 32'd0);
`endif
        @(posedge clk);
        #1;
        Y_in     = 1'b0;
        ALU_take = 1'b0;
        from_bus = '0;
        #1;
`ifdef Y_OPERAND_BYPASS_EN
        check("bypass after count", 32'(count), 32'd0);
        check("bypass after to_ALU", 32'(to_ALU), 32'h0000_0000);
`else
        check("empty push+pop after count", 32'(count), 32'd1);
        check("empty push+pop after to_ALU", 32'(to_ALU), 32'h0000_BEEF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
        $finish;
    end

endmodule
